// File: rtl/derandomizer.sv
// Receive-side descrambler for the 802.16 OFDM PRBS (1 + x^14 + x^15).
// Bit-serial valid/ready stream with one output register; the burst is framed by start/burst_len.
module derandomizer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       bsid,
  input  logic [3:0]       uiuc,
  input  logic [3:0]       fnum,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             drop_err
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  // lfsr_q[k] holds stage r[k+1]; the feedback taps are r[14] and r[15]
  logic [14:0]      lfsr_q, lfsr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             obit_q, obit_d;
  logic             ovld_q, ovld_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;

  logic             hs;
  logic             fb;
  logic [14:0]      seed;
  logic [LEN_W-1:0] cnt_inc;

  assign seed = {bsid[0], bsid[1], bsid[2], bsid[3], 1'b1, 1'b1,
                 uiuc[0], uiuc[1], uiuc[2], uiuc[3], 1'b1,
                 fnum[0], fnum[1], fnum[2], fnum[3]};

  assign fb       = lfsr_q[13] ^ lfsr_q[14];
  assign cnt_inc  = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
  assign in_ready = (state_q == S_RUN) & ~start & (~ovld_q | out_ready);
  assign hs       = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    obit_d  = obit_q;
    ovld_d  = ovld_q;
    done_d  = 1'b0;
    drop_d  = drop_q;

    if (ovld_q && out_ready) begin
      ovld_d = 1'b0;
    end

    if (hs) begin
      obit_d = in_bit ^ fb;
      ovld_d = 1'b1;
      lfsr_d = {lfsr_q[13:0], fb};
      cnt_d  = cnt_inc;
      if (cnt_inc == len_q) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    if ((state_q == S_IDLE) && in_valid) begin
      drop_d = 1'b1;
    end

    // start (re)seeds and reframes; any pending output bit is left to drain
    if (start) begin
      lfsr_d = seed;
      cnt_d  = '0;
      len_d  = burst_len;
      drop_d = 1'b0;
      if (burst_len == '0) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      obit_q  <= 1'b0;
      ovld_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      obit_q  <= obit_d;
      ovld_q  <= ovld_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign out_bit   = obit_q;
  assign out_valid = ovld_q;
  assign busy      = (state_q == S_RUN);
  assign done      = done_q;
  assign drop_err  = drop_q;

endmodule

// File: tb/tb_derandomizer.sv
// Directed bench for derandomizer: zero-seed burst, round trip, backpressure,
// mid-burst restart, zero-length burst, idle drop flag and reset mid-burst.
module tb_derandomizer;

  logic        clk = 1'b0;
  logic        reset, start, in_bit, in_valid, out_ready;
  logic [3:0]  bsid, uiuc, fnum;
  logic [15:0] burst_len;
  logic        in_ready, out_bit, out_valid, busy, done, drop_err;

  int checks   = 0;
  int failures = 0;

  logic dat[$];
  logic got[$];
  int   ndone;

  // Zero-seed keystream (all-zero input gives the keystream itself)
  logic [13:0] zseq = 14'b00010100011000; // MSB = first bit

  derandomizer #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .bsid(bsid), .uiuc(uiuc),
    .fnum(fnum), .burst_len(burst_len), .in_bit(in_bit), .in_valid(in_valid),
    .in_ready(in_ready), .out_bit(out_bit), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [3:0] b, input logic [3:0] u, input logic [3:0] f,
                          input logic [15:0] n);
    bsid = b; uiuc = u; fnum = f; burst_len = n; start = 1'b1; in_valid = 1'b0;
    cyc();
    start = 1'b0;
  endtask

  // Feed dat[0..max_acc-1]; optionally drain the output register afterwards.
  task automatic run(input int max_acc, input bit bp, input bit drain, input bit fin);
    int acc = 0;
    int n = 0;
    logic [3:0] pat = 4'b1001;
    while ((acc < max_acc || (drain && out_valid)) && n < 2000) begin
      in_valid  = (acc < max_acc);
      in_bit    = (acc < max_acc) ? dat[acc] : 1'b0;
      out_ready = bp ? pat[3 - (n % 4)] : 1'b1;
      #3;
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      if (out_valid && out_ready) got.push_back(out_bit);
      if (in_valid && in_ready) acc++;
      cyc();
      if (done) ndone++;
      if (fin && in_valid && acc == max_acc) begin
        check("end_busy", busy, 0);
        check("end_done", done, 1);
        in_valid = 1'b0;
      end
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (n >= 2000) check("run_timeout", 1, 0);
  endtask

  task automatic zero_data(input int n);
    dat.delete();
    for (int i = 0; i < n; i++) dat.push_back(1'b0);
  endtask

  task automatic check_zseq(input string tag, input int offs);
    int bad = 0;
    for (int i = 0; i < 14; i++) if (got[offs + i] !== zseq[13 - i]) bad++;
    check(tag, bad, 0);
  endtask

  initial begin
    logic [15:1] r;
    logic        f, orig[$];
    int          bad;

    reset = 1'b1; start = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    bsid = 4'h0; uiuc = 4'h0; fnum = 4'h0; burst_len = 16'd0;
    cyc(); cyc();
    reset = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop_err", drop_err, 0);
    cyc();

    // Zero-seed burst
    zero_data(14); got.delete(); ndone = 0;
    do_start(4'h0, 4'h0, 4'h0, 16'd14);
    check("zs_busy_after_start", busy, 1);
    run(14, 1'b0, 1'b1, 1'b1);
    check("zs_beats", got.size(), 14);
    check_zseq("zs_seq", 0);
    check("zs_done_count", ndone, 1);

    // Backpressure on the same burst
    got.delete(); ndone = 0;
    do_start(4'h0, 4'h0, 4'h0, 16'd14);
    run(14, 1'b1, 1'b1, 1'b1);
    check("bp_beats", got.size(), 14);
    check_zseq("bp_seq", 0);
    check("bp_done_count", ndone, 1);

    // Round trip: bench-side randomizer seeded in r[1..15] order
    orig.delete(); dat.delete(); got.delete(); ndone = 0;
    r = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    // r[15..1]: bsid A -> r12..15 = 1,0,1,0 ; fnum 3 -> r1..4 = 0,0,1,1
    r[1] = 1'b0; r[2] = 1'b0; r[3] = 1'b1; r[4] = 1'b1; r[5] = 1'b1;
    r[6] = 1'b0; r[7] = 1'b1; r[8] = 1'b0; r[9] = 1'b1; r[10] = 1'b1; r[11] = 1'b1;
    r[12] = 1'b1; r[13] = 1'b0; r[14] = 1'b1; r[15] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      orig.push_back(1'($urandom_range(0, 1)));
      f = r[14] ^ r[15];
      dat.push_back(orig[i] ^ f);
      r = {r[14:1], f};
    end
    do_start(4'hA, 4'h5, 4'h3, 16'd256);
    run(256, 1'b0, 1'b1, 1'b1);
    check("rt_beats", got.size(), 256);
    bad = 0;
    for (int i = 0; i < 256 && i < got.size(); i++) if (got[i] !== orig[i]) bad++;
    check("rt_data", bad, 0);
    check("rt_drop_err", drop_err, 0);
    check("rt_done_count", ndone, 1);

    // Mid-burst restart with a pending 5th bit held across start
    zero_data(14); got.delete(); ndone = 0;
    do_start(4'h0, 4'h0, 4'h0, 16'd14);
    run(5, 1'b0, 1'b0, 1'b0);
    check("mr_pending", out_valid, 1);
    bsid = 4'h0; uiuc = 4'h0; fnum = 4'h0; burst_len = 16'd14;
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    #3;
    check("mr_in_ready_on_start", in_ready, 0);
    cyc();
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("mr_pending_kept", out_valid, 1);
    check("mr_busy", busy, 1);
    run(14, 1'b0, 1'b1, 1'b1);
    check("mr_beats", got.size(), 19);
    if (got.size() == 19) begin
      check("mr_fifth", got[4], zseq[9]);
      check_zseq("mr_fresh_seq", 5);
    end
    check("mr_done_count", ndone, 1);

    // Zero-length burst
    do_start(4'h1, 4'h2, 4'h3, 16'd0);
    check("z0_done", done, 1);
    check("z0_busy", busy, 0);
    cyc();
    check("z0_done_clear", done, 0);
    check("z0_busy_stays", busy, 0);

    // Input while idle
    in_valid = 1'b1; in_bit = 1'b1;
    #3;
    check("idle_in_ready", in_ready, 0);
    cyc();
    in_valid = 1'b0;
    check("drop_set", drop_err, 1);
    cyc(); cyc(); cyc();
    check("drop_sticky", drop_err, 1);
    do_start(4'h0, 4'h0, 4'h0, 16'd0);
    check("drop_cleared", drop_err, 0);

    // Reset mid-burst with a pending output bit
    zero_data(14); got.delete(); ndone = 0;
    do_start(4'h0, 4'h0, 4'h0, 16'd14);
    run(7, 1'b0, 1'b0, 1'b0);
    check("rm_pending", out_valid, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #3;
    check("rm_in_ready", in_ready, 0);
    check("rm_out_valid", out_valid, 0);
    check("rm_out_bit", out_bit, 0);
    check("rm_busy", busy, 0);
    check("rm_done", done, 0);
    check("rm_drop_err", drop_err, 0);
    cyc();
    got.delete(); ndone = 0;
    do_start(4'h0, 4'h0, 4'h0, 16'd14);
    run(14, 1'b0, 1'b1, 1'b1);
    check("rm_beats", got.size(), 14);
    check_zseq("rm_seq", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/derandomizer.md
# derandomizer

Receive-side counterpart of the transmit randomizer. It strips the 802.16 OFDM PRBS (1 + x^14 + x^15) from a bit-serial burst. Per burst it builds the 15-bit seed from BSID, UIUC and frame number, descrambles exactly `burst_len` bits through a valid/ready pipeline stage, then returns to idle and pulses `done`. It sits between the deinterleaver/decoder output and the MAC bit sink.

## Interface
- `LEN_W`, 16: width of the burst length and the bit counter.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: begin a burst; latches `bsid`, `uiuc`, `fnum` and `burst_len`.
- `bsid` input 4: BSID LSBs.
- `uiuc` input 4: UIUC.
- `fnum` input 4: frame number LSBs.
- `burst_len` input LEN_W: number of bits in the burst; 0 is legal.
- `in_bit` input 1: scrambled data bit.
- `in_valid` input 1: `in_bit` is valid.
- `in_ready` output 1: block accepts `in_bit` this cycle.
- `out_bit` output 1: descrambled bit.
- `out_valid` output 1: `out_bit` is valid.
- `out_ready` input 1: sink accepts `out_bit`.
- `busy` output 1: a burst is in progress (state RUN).
- `done` output 1: one-cycle pulse when the last bit of a burst is accepted on the input.
- `drop_err` output 1: sticky; set when `in_valid` is high while in IDLE. Cleared by `reset` or `start`.

## Operation
- Seed: s[0:14] = {fnum[3], fnum[2], fnum[1], fnum[0], 1, uiuc[3], uiuc[2], uiuc[1], uiuc[0], 1, 1, bsid[3], bsid[2], bsid[1], bsid[0]}. s[k] loads LFSR stage r[k+1], for stages r[1..15].
- Per accepted bit:
  - fb = r[14] ^ r[15]
  - out = in_bit ^ fb
  - r <= {fb, r[1..14]}
- The LFSR advances only on an input handshake (`in_valid & in_ready`).
- State machine, two states:
  - IDLE -> RUN on `start` when `burst_len` != 0.
  - IDLE stays in IDLE on `start` when `burst_len` == 0, and `done` pulses on the next cycle.
  - RUN -> IDLE on the handshake that makes count == `burst_len`; `done` pulses in that same cycle (registered, so visible on the following edge).
  - `start` while in RUN aborts the burst: reseed, clear the count, latch the new length, remain in RUN.
- Bit counter: LEN_W bits, cleared on `start`, incremented per input handshake. It never wraps, because the burst ends at `burst_len`.
- Output stage: one register. `in_ready` = RUN & !start & (!out_valid | out_ready).
  - The output register loads on an input handshake.
  - `out_valid` clears on an output handshake that has no new load.
  - A pending output bit survives `start` and burst end, and is delivered normally.
- Input in IDLE is not consumed (`in_ready` = 0) and sets `drop_err`.

## Timing
- Reset values:
  - state IDLE, LFSR all zeros, count 0.
  - `in_ready` 0, `out_valid` 0, `out_bit` 0, `busy` 0, `done` 0, `drop_err` 0.
- `reset` overrides everything, including mid-burst; the pending output is discarded.
- `start` sampled at edge N: `busy` = 1 and LFSR = seed after edge N. `in_ready` can first be 1 in cycle N+1.
- Latency: an input handshake at edge N gives `out_valid` = 1 with the result after edge N (1 cycle).
- Throughput: 1 bit per clock while `out_ready` = 1.
- When `out_ready` = 0 with `out_valid` = 1: `in_ready` = 0, and the LFSR and count hold.
- `start` and an input handshake never coincide, because `in_ready` is gated by `start`.
- `done` and `busy` falling occur on the same edge as the final input handshake.

## Test plan
- **Zero-seed burst.** bsid = uiuc = fnum = 0, `burst_len` = 14, input all zeros, `out_ready` = 1.
  - Output is 0,0,0,1,0,1,0,0,0,1,1,0,0,0.
  - Exactly 14 `out_valid` beats; `done` pulses once; `busy` falls after the 14th accept.
- **Round trip.** Randomizer feeds derandomizer, both seeded with bsid = 4'hA, uiuc = 4'h5, fnum = 4'h3, 256 random bits.
  - Output equals the original data.
  - `drop_err` = 0.
- **Backpressure.** Toggle `out_ready` 1,0,0,1 repeatedly during the zero-seed burst.
  - Same 14-bit output sequence, with no bit lost or duplicated.
  - `in_ready` = 0 whenever `out_valid` & !`out_ready`.
- **Mid-burst restart.** Assert `start` after 5 bits with the zero seed and `burst_len` = 14.
  - The 5th output bit is still delivered.
  - Then 14 fresh bits 0,0,0,1,0,1,0,0,0,1,1,0,0,0.
  - `done` pulses only at the end.
- **Edge cases.**
  - `start` with `burst_len` = 0: `done` pulses after 1 cycle, and `busy` stays 0.
  - `in_valid` = 1 while idle: `drop_err` = 1 and stays set until the next `start`.
- **Reset mid-burst.** Assert `reset` for 1 cycle after 7 bits, with `out_valid` = 1.
  - All outputs return to their reset values.
  - A following burst reproduces the zero-seed sequence.
